rf_operand_collector: RTL

- Read-side master for register_bank: accepts operand-fetch requests (two source regs + lane mask) from issue, drives both bank read ports, captures 16-lane x 64-bit operand vectors.
- Forwards same-cycle writeback data so a capture never returns the stale pre-write value.
- Buffers captured operands in a small in-order queue toward the execute stage.
- Sits between warp issue and the ALU lanes; register_bank reads are combinational, writes commit at posedge clk.

---
 rtl/rf_operand_collector.sv | 119 +++++++++++
 1 files changed

// File: rtl/rf_operand_collector.sv
// Operand collector: fetches two source vectors from the register bank on request,
// bypasses same-edge writeback, and queues captured operands in order toward execute.
module rf_operand_collector #(
  parameter int unsigned NUM_LANES = 16,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned TAG_W     = 6,
  parameter int unsigned DEPTH     = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [ADDR_W-1:0]           req_src0,
  input  logic [ADDR_W-1:0]           req_src1,
  input  logic [NUM_LANES-1:0]        req_mask,
  input  logic [TAG_W-1:0]            req_tag,
  output logic [NUM_LANES-1:0]        read_en_0,
  output logic [NUM_LANES-1:0]        read_en_1,
  output logic [ADDR_W-1:0]           raddr_0,
  output logic [ADDR_W-1:0]           raddr_1,
  input  logic [NUM_LANES*DATA_W-1:0] rdata_0,
  input  logic [NUM_LANES*DATA_W-1:0] rdata_1,
  input  logic [NUM_LANES-1:0]        wb_en,
  input  logic [ADDR_W-1:0]           wb_addr,
  input  logic [NUM_LANES*DATA_W-1:0] wb_data,
  output logic                        op_valid,
  input  logic                        op_ready,
  output logic [NUM_LANES*DATA_W-1:0] op_a,
  output logic [NUM_LANES*DATA_W-1:0] op_b,
  output logic [NUM_LANES-1:0]        op_mask,
  output logic [TAG_W-1:0]            op_tag
);

  localparam int unsigned VEC_W = NUM_LANES * DATA_W;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DepthC  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LastPtr = PTR_W'(DEPTH - 1);

  logic [CNT_W-1:0]     count_q;
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [VEC_W-1:0]     a_q    [DEPTH];
  logic [VEC_W-1:0]     b_q    [DEPTH];
  logic [NUM_LANES-1:0] mask_q [DEPTH];
  logic [TAG_W-1:0]     tag_q  [DEPTH];

  logic             accept, pop;
  logic [VEC_W-1:0] cap_a, cap_b;

  always_comb begin
    req_ready = rst_n && ((count_q < DepthC) || ((count_q == DepthC) && op_ready));
    accept    = req_valid && req_ready;
    op_valid  = (count_q != '0);
    pop       = op_valid && op_ready;
    read_en_0 = accept ? req_mask : '0;
    read_en_1 = accept ? req_mask : '0;
    raddr_0   = accept ? req_src0 : '0;
    raddr_1   = accept ? req_src1 : '0;
  end

  // The bank commits a write at the same edge we capture, so matching lanes take wb_data.
  always_comb begin
    cap_a = '0;
    cap_b = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (req_mask[l]) begin
        cap_a[l*DATA_W +: DATA_W] = (wb_en[l] && (wb_addr == req_src0)) ?
                                    wb_data[l*DATA_W +: DATA_W] : rdata_0[l*DATA_W +: DATA_W];
        cap_b[l*DATA_W +: DATA_W] = (wb_en[l] && (wb_addr == req_src1)) ?
                                    wb_data[l*DATA_W +: DATA_W] : rdata_1[l*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    op_a    = '0;
    op_b    = '0;
    op_mask = '0;
    op_tag  = '0;
    if (op_valid) begin
      op_a    = a_q[rd_ptr_q];
      op_b    = b_q[rd_ptr_q];
      op_mask = mask_q[rd_ptr_q];
      op_tag  = tag_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        a_q[i]    <= '0;
        b_q[i]    <= '0;
        mask_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      if (accept) begin
        a_q[wr_ptr_q]    <= cap_a;
        b_q[wr_ptr_q]    <= cap_b;
        mask_q[wr_ptr_q] <= req_mask;
        tag_q[wr_ptr_q]  <= req_tag;
        wr_ptr_q         <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      end
      if (accept && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !accept) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule
